// File: rtl/noc_pkg.sv
// Shared NoC parameters, arbiter state encoding, port indices and a one-hot helper.
package noc_pkg;

    localparam int FLIT_SIZE           = 4;
    localparam int PACKET_SIZE         = 32;
    localparam int ADDRESS_SIZE        = 16;
    localparam int PORT_NUMBER         = 5;
    localparam int FLIT_NUMBER         = PACKET_SIZE / FLIT_SIZE;
    localparam int ADDRESS_FLIT_NUMBER = ADDRESS_SIZE / FLIT_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Index of the set bit in a one-hot vector of up to eight ports.
    function automatic logic [2:0] onehot_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping modulo n.
module rr_priority_pick #(
    parameter int n     = 5,
    parameter int ptr_w = (n > 1) ? $clog2(n) : 1
) (
    input  logic [n-1:0]     request,
    input  logic [ptr_w-1:0] pointer,
    output logic [n-1:0]     winner,
    output logic             found
);

    localparam logic [ptr_w:0] n_ext = (ptr_w + 1)'(n);

    logic [ptr_w:0]   sum_s;
    logic [ptr_w-1:0] idx_s;

    // Scan n candidates starting at the pointer and keep the first hit.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum_s  = '0;
        idx_s  = '0;
        for (int k = 0; k < n; k++) begin
            sum_s = {1'b0, pointer} + (ptr_w + 1)'(k);
            if (sum_s >= n_ext) begin
                sum_s = sum_s - n_ext;
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[ptr_w-1:0];
            if (!found && request[idx_s]) begin
                winner[idx_s] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-direction output port arbiter: round-robin grant held for one packet of flits.
// Optional stuck-requester watchdog enabled by defining ARB_WATCHDOG_EN.
module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int port_number  = PORT_NUMBER,
    parameter int flit_size    = FLIT_SIZE,
    parameter int packet_size  = PACKET_SIZE,
    parameter int address_size = ADDRESS_SIZE
`ifdef ARB_WATCHDOG_EN
    ,
    parameter int watchdog_cycles = 64
`endif
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [port_number-1:0]           request,
    input  logic [port_number-1:0]           flit_valid,
    input  logic [port_number*flit_size-1:0] flit_in,
    input  logic                             downstream_full,
    output logic [port_number-1:0]           grant,
    output logic [port_number-1:0]           stall,
    output logic [port_number-1:0]           destination_full,
    output logic [flit_size-1:0]             flit_out,
    output logic                             flit_out_valid,
    output logic                             packet_done
`ifdef ARB_WATCHDOG_EN
    ,
    output logic                             watchdog_error
`endif
);

    localparam int flit_number = packet_size / flit_size;
    localparam int cnt_w       = $clog2(flit_number);
    localparam int ptr_w       = $clog2(port_number);
    localparam logic [cnt_w-1:0] last_cnt  = cnt_w'(flit_number - 1);
    localparam logic [ptr_w-1:0] last_port = ptr_w'(port_number - 1);

    if (port_number < 2 || port_number > 8) begin : g_bad_port_number
        $error("output_port_arbiter: port_number must be 2..8");
    end
    if ((packet_size % flit_size) != 0 || (address_size % flit_size) != 0) begin : g_bad_sizes
        $error("output_port_arbiter: packet and address sizes must be whole flits");
    end

    arb_state_t             state_r;
    logic [port_number-1:0] grant_r;
    logic [cnt_w-1:0]       cnt_r;
    logic [ptr_w-1:0]       ptr_r;
    logic                   done_r;

    logic [port_number-1:0] winner_s;
    logic                   found_s;
    logic                   accept_s;
    logic [ptr_w-1:0]       grant_idx_s;
    logic [ptr_w-1:0]       next_ptr_s;
    logic [flit_size-1:0]   flit_mux_s;

`ifdef ARB_WATCHDOG_EN
    localparam int wd_w = $clog2(watchdog_cycles + 1);
    localparam logic [wd_w-1:0] wd_last = wd_w'(watchdog_cycles - 1);
    logic [wd_w-1:0] wd_cnt_r;
    logic            wd_err_r;
    assign watchdog_error = wd_err_r;
`endif

    rr_priority_pick #(
        .n     (port_number),
        .ptr_w (ptr_w)
    ) u_pick (
        .request (request),
        .pointer (ptr_r),
        .winner  (winner_s),
        .found   (found_s)
    );

    assign accept_s    = (|(flit_valid & grant_r)) & ~downstream_full;
    assign grant_idx_s = ptr_w'(onehot_index(8'(grant_r)));
    assign next_ptr_s  = (grant_idx_s == last_port) ? {ptr_w{1'b0}} : grant_idx_s + 1'b1;

    assign grant            = grant_r;
    assign packet_done      = done_r;
    assign stall            = request & ~grant_r;
    assign destination_full = {port_number{downstream_full}} | ~grant_r;
    assign flit_out_valid   = accept_s;
    assign flit_out         = flit_mux_s;

    // AND-OR mux of the granted port's flit; zero with no grant.
    always_comb begin
        flit_mux_s = '0;
        for (int i = 0; i < port_number; i++) begin
            flit_mux_s = flit_mux_s | ({flit_size{grant_r[i]}} & flit_in[i*flit_size +: flit_size]);
        end
    end

    // Arbitration FSM: grant in IDLE, count accepted flits in BUSY, release on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            cnt_r    <= '0;
            ptr_r    <= '0;
            done_r   <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_r <= '0;
            wd_err_r <= 1'b0;
`endif
        end else begin
            done_r   <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r  <= winner_s;
                        cnt_r    <= '0;
                        state_r  <= BUSY;
`ifdef ARB_WATCHDOG_EN
                        wd_cnt_r <= '0;
`endif
                    end else begin
                        grant_r  <= '0;
                    end
                end
                BUSY: begin
                    if (accept_s) begin
`ifdef ARB_WATCHDOG_EN
                        wd_cnt_r <= '0;
`endif
                        if (cnt_r == last_cnt) begin
                            grant_r <= '0;
                            done_r  <= 1'b1;
                            ptr_r   <= next_ptr_s;
                            cnt_r   <= '0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r   <= cnt_r + 1'b1;
                        end
`ifdef ARB_WATCHDOG_EN
                    end else if (!downstream_full && wd_cnt_r == wd_last) begin
                        // Holder starved the link: drop it without a packet_done.
                        grant_r  <= '0;
                        ptr_r    <= next_ptr_s;
                        cnt_r    <= '0;
                        wd_cnt_r <= '0;
                        wd_err_r <= 1'b1;
                        state_r  <= IDLE;
                    end else if (!downstream_full) begin
                        wd_cnt_r <= wd_cnt_r + 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    grant_r <= '0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
